// File: rtl/serial_full_subtractor_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : serial_full_subtractor_if
// Purpose  : Start/operand/result bundle for the bit-serial subtractor.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
interface serial_full_subtractor_if #(
  parameter int N = 8
) ();
  logic         start;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         bin;
  logic         busy;
  logic         done;
  logic [N-1:0] diff;
  logic         bout;

  modport master (output start, a, b, bin, input busy, done, diff, bout);
  modport slave  (input start, a, b, bin, output busy, done, diff, bout);
endinterface
`default_nettype wire

// File: rtl/serial_full_subtractor.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : serial_full_subtractor
// Purpose  : Bit-serial N-bit subtractor (a - b - bin), LSB first, one bit
//            per clock through a single full-subtractor cell and borrow flop.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
module serial_full_subtractor #(
  parameter int N = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  serial_full_subtractor_if.slave  bus
);

  localparam int           CW     = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] C_LAST = CW'(N - 1);
  localparam logic [CW-1:0] C_ONE  = CW'(1);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [N-1:0]  a_sr_q, a_sr_d;
  logic [N-1:0]  b_sr_q, b_sr_d;
  logic [N-1:0]  res_q, res_d;
  logic          brw_q, brw_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N-1:0]  diff_q, diff_d;
  logic          bout_q, bout_d;
  logic          done_q, done_d;

  // Full-subtractor cell operating on the current LSBs and the borrow flop.
  logic w_x, w_y, w_c, w_d, w_bnext;
  assign w_x     = a_sr_q[0];
  assign w_y     = b_sr_q[0];
  assign w_c     = brw_q;
  assign w_d     = w_x ^ w_y ^ w_c;
  assign w_bnext = (~w_x & w_y) | (~(w_x ^ w_y) & w_c);

  // State and datapath registers; reset clears everything including outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_sr_q  <= '0;
      b_sr_q  <= '0;
      res_q   <= '0;
      brw_q   <= 1'b0;
      cnt_q   <= '0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sr_q  <= a_sr_d;
      b_sr_q  <= b_sr_d;
      res_q   <= res_d;
      brw_q   <= brw_d;
      cnt_q   <= cnt_d;
      diff_q  <= diff_d;
      bout_q  <= bout_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic: capture on start in IDLE, one bit per cycle in RUN,
  // publish the result only on the edge that processes the MSB.
  always_comb begin
    state_d = state_q;
    a_sr_d  = a_sr_q;
    b_sr_d  = b_sr_q;
    res_d   = res_q;
    brw_d   = brw_q;
    cnt_d   = cnt_q;
    diff_d  = diff_q;
    bout_d  = bout_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          a_sr_d  = bus.a;
          b_sr_d  = bus.b;
          brw_d   = bus.bin;
          res_d   = '0;
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        a_sr_d = {1'b0, a_sr_q[N-1:1]};
        b_sr_d = {1'b0, b_sr_q[N-1:1]};
        res_d  = {w_d, res_q[N-1:1]};
        brw_d  = w_bnext;
        cnt_d  = cnt_q + C_ONE;
        if (cnt_q == C_LAST) begin
          diff_d  = {w_d, res_q[N-1:1]};
          bout_d  = w_bnext;
          done_d  = 1'b1;
          cnt_d   = '0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.busy = (state_q == S_RUN);
  assign bus.done = done_q;
  assign bus.diff = diff_q;
  assign bus.bout = bout_q;

endmodule
`default_nettype wire
